// File: rtl/alu_seq.sv
// Registered W-bit ALU with a START/BUSY/DONE handshake.
// Single-cycle ops complete in one clock; MUL iterates shift-add over W clocks.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [2:0]   OP,
    output logic [W-1:0] R,
    output logic [W-1:0] RH,
    output logic         CF,
    output logic         ZF,
    output logic         SF,
    output logic         OF,
    output logic         BUSY,
    output logic         DONE
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] W_VAL = W'(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_AND = 3'b001,
        OP_SHR = 3'b010,
        OP_SUB = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t          state, state_d;
    logic [W-1:0]    mcand, mcand_d;
    logic [2*W-1:0]  prod, prod_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [W-1:0]    r_d, rh_d;
    logic            cf_d, zf_d, sf_d, of_d, busy_d, done_d;

    logic [W-1:0]    alu_r;
    logic            alu_cf, alu_of;
    logic [W:0]      add_full, sub_full, shr_full, shl_full;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;

    // Single-cycle result and carry/overflow for the non-MUL ops.
    always_comb begin
        alu_r    = '0;
        alu_cf   = 1'b0;
        alu_of   = 1'b0;
        add_full = {1'b0, A} + {1'b0, B};
        sub_full = {1'b0, A} - {1'b0, B};
        shr_full = {A, 1'b0} >> B;
        shl_full = {1'b0, A} << B;
        case (op_t'(OP))
            OP_ADD: begin
                alu_r  = add_full[W-1:0];
                alu_cf = add_full[W];
                alu_of = (A[W-1] == B[W-1]) && (add_full[W-1] != A[W-1]);
            end
            OP_SUB: begin
                alu_r  = sub_full[W-1:0];
                alu_cf = sub_full[W];
                alu_of = (A[W-1] != B[W-1]) && (sub_full[W-1] != A[W-1]);
            end
            OP_AND: alu_r = A & B;
            OP_OR:  alu_r = A | B;
            OP_XOR: alu_r = A ^ B;
            OP_SHR: begin
                // Shifting by W or more empties the word with no carry-out
                if (B < W_VAL) begin
                    alu_r  = shr_full[W:1];
                    alu_cf = shr_full[0];
                end
            end
            OP_SHL: begin
                if (B < W_VAL) begin
                    alu_r  = shl_full[W-1:0];
                    alu_cf = shl_full[W];
                end
            end
            default: ;
        endcase
    end

    // Upper half accumulates the multiplicand while the multiplier shifts out of the lower half.
    assign mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, prod[W-1:1]};

    always_comb begin
        state_d = state;
        mcand_d = mcand;
        prod_d  = prod;
        cnt_d   = cnt;
        r_d     = R;
        rh_d    = RH;
        cf_d    = CF;
        zf_d    = ZF;
        sf_d    = SF;
        of_d    = OF;
        busy_d  = BUSY;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    if (op_t'(OP) == OP_MUL) begin
                        mcand_d = A;
                        prod_d  = {{W{1'b0}}, B};
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = MUL;
                    end else begin
                        r_d    = alu_r;
                        rh_d   = '0;
                        cf_d   = alu_cf;
                        of_d   = alu_of;
                        zf_d   = (alu_r == '0);
                        sf_d   = alu_r[W-1];
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt + CW'(1);
                if (cnt == LAST_ITER) begin
                    r_d     = mul_next[W-1:0];
                    rh_d    = mul_next[2*W-1:W];
                    cf_d    = |mul_next[2*W-1:W];
                    of_d    = |mul_next[2*W-1:W];
                    zf_d    = ~|mul_next;
                    sf_d    = mul_next[W-1];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            R     <= '0;
            RH    <= '0;
            CF    <= 1'b0;
            ZF    <= 1'b0;
            SF    <= 1'b0;
            OF    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_d;
            mcand <= mcand_d;
            prod  <= prod_d;
            cnt   <= cnt_d;
            R     <= r_d;
            RH    <= rh_d;
            CF    <= cf_d;
            ZF    <= zf_d;
            SF    <= sf_d;
            OF    <= of_d;
            BUSY  <= busy_d;
            DONE  <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at W=8 plus hand-written
// sequences for ignored START, back-to-back ops and reset during MUL.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         START;
    logic [W-1:0] A, B;
    logic [2:0]   OP;
    logic [W-1:0] R, RH;
    logic         CF, ZF, SF, OF, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    alu_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .START (START),
        .A     (A),
        .B     (B),
        .OP    (OP),
        .R     (R),
        .RH    (RH),
        .CF    (CF),
        .ZF    (ZF),
        .SF    (SF),
        .OF    (OF),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] rh;
        logic         cf;
        logic         zf;
        logic         sf;
        logic         of;
        int           lat;
    } vec_t;

    localparam logic [2:0] ADD = 3'b000, AND_ = 3'b001, SHR = 3'b010, SUB = 3'b011;
    localparam logic [2:0] OR_ = 3'b100, XOR_ = 3'b101, SHL = 3'b110, MUL = 3'b111;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one op and waits (bounded) for DONE; lat=0 means DONE never came.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int lat, output int busyBad);
        @(negedge clk);
        START = 1'b1;
        OP    = op;
        A     = a;
        B     = b;
        lat     = 0;
        busyBad = 0;
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge clk);
            START = 1'b0;
            if (DONE) begin
                lat = k;
                if (BUSY) busyBad++;
                break;
            end
            if (!BUSY) busyBad++;
        end
    endtask

    task automatic checkResult(input vec_t v, input int lat, input int busyBad);
        checkOutput({v.name, " R"},   64'(R),  64'(v.r));
        checkOutput({v.name, " RH"},  64'(RH), 64'(v.rh));
        checkOutput({v.name, " CF"},  64'(CF), 64'(v.cf));
        checkOutput({v.name, " ZF"},  64'(ZF), 64'(v.zf));
        checkOutput({v.name, " SF"},  64'(SF), 64'(v.sf));
        checkOutput({v.name, " OF"},  64'(OF), 64'(v.of));
        checkOutput({v.name, " latency"}, 64'(lat), 64'(v.lat));
        checkOutput({v.name, " busy"}, 64'(busyBad), 64'(0));
    endtask

    vec_t vecs[$];

    initial begin
        int lat, busyBad, doneCount;
        vec_t v;

        vecs.push_back('{"add_ff_01",  ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0, 1});
        vecs.push_back('{"add_7f_01",  ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1, 1, 1});
        vecs.push_back('{"sub_05_07",  SUB,  8'h05, 8'h07, 8'hFE, 8'h00, 1, 0, 1, 0, 1});
        vecs.push_back('{"sub_80_01",  SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 0, 0, 0, 1, 1});
        vecs.push_back('{"add_80_80",  ADD,  8'h80, 8'h80, 8'h00, 8'h00, 1, 1, 0, 1, 1});
        vecs.push_back('{"shr_96_3",   SHR,  8'h96, 8'h03, 8'h12, 8'h00, 1, 0, 0, 0, 1});
        vecs.push_back('{"shl_96_1",   SHL,  8'h96, 8'h01, 8'h2C, 8'h00, 1, 0, 0, 0, 1});
        vecs.push_back('{"shr_96_9",   SHR,  8'h96, 8'h09, 8'h00, 8'h00, 0, 1, 0, 0, 1});
        vecs.push_back('{"shr_96_0",   SHR,  8'h96, 8'h00, 8'h96, 8'h00, 0, 0, 1, 0, 1});
        vecs.push_back('{"shr_96_8",   SHR,  8'h96, 8'h08, 8'h00, 8'h00, 0, 1, 0, 0, 1});
        vecs.push_back('{"shl_96_8",   SHL,  8'h96, 8'h08, 8'h00, 8'h00, 0, 1, 0, 0, 1});
        vecs.push_back('{"shl_96_7",   SHL,  8'h96, 8'h07, 8'h00, 8'h00, 1, 1, 0, 0, 1});
        vecs.push_back('{"shr_96_7",   SHR,  8'h96, 8'h07, 8'h01, 8'h00, 0, 0, 0, 0, 1});
        vecs.push_back('{"and_f0_3c",  AND_, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0, 1});
        vecs.push_back('{"or_f0_0c",   OR_,  8'hF0, 8'h0C, 8'hFC, 8'h00, 0, 0, 1, 0, 1});
        vecs.push_back('{"xor_aa_aa",  XOR_, 8'hAA, 8'hAA, 8'h00, 8'h00, 0, 1, 0, 0, 1});
        vecs.push_back('{"mul_ff_ff",  MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1, 0, 0, 1, W + 1});
        vecs.push_back('{"mul_00_37",  MUL,  8'h00, 8'h37, 8'h00, 8'h00, 0, 1, 0, 0, W + 1});
        vecs.push_back('{"mul_0f_11",  MUL,  8'h0F, 8'h11, 8'hFF, 8'h00, 0, 0, 1, 0, W + 1});
        vecs.push_back('{"add_01_01",  ADD,  8'h01, 8'h01, 8'h02, 8'h00, 0, 0, 0, 0, 1});

        START = 1'b0;
        OP    = '0;
        A     = '0;
        B     = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", 64'({R, RH, CF, ZF, SF, OF, BUSY, DONE}), 64'(0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyBad);
            checkResult(vecs[i], lat, busyBad);
            @(negedge clk);
            checkOutput({vecs[i].name, " done pulse"}, 64'(DONE), 64'(0));
        end

        // Back-to-back single-cycle ops keep DONE high on consecutive cycles
        @(negedge clk);
        START = 1'b1; OP = ADD; A = 8'h10; B = 8'h22;
        @(negedge clk);
        checkOutput("b2b first R", 64'(R), 64'(8'h32));
        checkOutput("b2b first DONE", 64'(DONE), 64'(1));
        OP = XOR_; A = 8'hFF; B = 8'h0F;
        @(negedge clk);
        START = 1'b0;
        checkOutput("b2b second R", 64'(R), 64'(8'hF0));
        checkOutput("b2b second DONE", 64'(DONE), 64'(1));
        checkOutput("b2b second SF", 64'(SF), 64'(1));

        // START with ADD during a MUL must be dropped entirely
        @(negedge clk);
        START = 1'b1; OP = MUL; A = 8'h10; B = 8'h10;
        @(negedge clk);
        START = 1'b0;
        @(negedge clk);
        START = 1'b1; OP = ADD; A = 8'h01; B = 8'h01;
        @(negedge clk);
        START = 1'b0;
        doneCount = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (DONE) doneCount++;
            @(negedge clk);
        end
        checkOutput("ignored start done count", 64'(doneCount), 64'(1));
        checkOutput("ignored start R", 64'(R), 64'(8'h00));
        checkOutput("ignored start RH", 64'(RH), 64'(8'h01));
        checkOutput("ignored start CF", 64'(CF), 64'(1));

        // Reset three cycles into a MUL aborts it with no DONE
        START = 1'b1; OP = MUL; A = 8'hFF; B = 8'hFF;
        @(negedge clk);
        START = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid mul busy", 64'(BUSY), 64'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("mid mul reset outputs", 64'({R, RH, CF, ZF, SF, OF, BUSY, DONE}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (DONE || BUSY) doneCount++;
        end
        checkOutput("aborted mul no done", 64'(doneCount), 64'(0));

        v = '{"post_reset_and", AND_, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0, 1};
        applyStimulus(v.op, v.a, v.b, lat, busyBad);
        checkResult(v, lat, busyBad);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU that succeeds the 4-bit combinational ALU. It extends the operand width to W bits and the op set to eight, adds an OF flag, and adds a START/BUSY/DONE handshake. Single-cycle ops finish in one clock; unsigned multiply runs iteratively over W clocks. Flags are recomputed on every operation and never carried over from a previous one. The block sits between the datapath register file and the result writeback stage.

## Interface
- W, 8: operand and result width; supported range 4 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- START  input  1  request; sampled on a rising edge.
- A  input  W  operand A; sampled together with START.
- B  input  W  operand B, or the shift amount.
- OP  input  3  opcode:
  - 000 ADD, 001 AND, 010 SHR: same encodings as the 4-bit ALU.
  - 011 SUB, 100 OR, 101 XOR, 110 SHL, 111 MUL.
- R  output  W  result; the low half for MUL.
- RH  output  W  high half of the MUL product; 0 for all other ops.
- CF  output  1  carry/borrow/shift-out flag.
- ZF  output  1  zero flag.
- SF  output  1  sign flag, equal to R[W-1].
- OF  output  1  signed overflow flag.
- BUSY  output  1  a MUL is in progress.
- DONE  output  1  one-cycle pulse; the result and flags are valid.

## Operation
- Reset (asynchronous): R, RH, CF, ZF, SF, OF, BUSY and DONE all go to 0. The FSM goes to IDLE and the iteration counter clears.
- States: IDLE and MUL.
- IDLE, START=1, OP not MUL:
  - Compute the result, write R, RH and all flags, and pulse DONE.
  - Stay in IDLE.
- IDLE, START=1, OP=MUL:
  - Latch A and B, clear the accumulator and counter, and set BUSY.
  - Go to MUL.
- MUL:
  - Do one shift-add iteration per clock, W iterations in total.
  - After the W-th iteration, write R and RH, write the flags, clear BUSY, pulse DONE, and return to IDLE.
- A START seen while BUSY=1 is ignored entirely. It is not queued, and the operands are not resampled.
- R, RH and the flags hold their values between operations. They change only at completion.
- Arithmetic and flags per op:
  - ADD: {CF,R}=A+B. OF=1 when A and B have the same sign and R's sign differs.
  - SUB: R=A-B, modulo 2^W. CF=1 on borrow, i.e. A<B unsigned. OF=1 when A and B have different signs and R's sign differs from A's.
  - AND, OR, XOR: bitwise. CF=0, OF=0.
  - SHR and SHL (logical, zero fill):
    - Shift by B.
    - CF is the last bit shifted out.
    - B=0 gives R=A and CF=0.
    - B>=W gives R=0 and CF=0.
    - OF=0.
  - MUL: unsigned W×W product, with {RH,R} holding the full 2W bits. CF=OF=(RH!=0).
- ZF=1 when R==0. For MUL, ZF=1 only when both R and RH are 0.
- SF=R[W-1] for every op.

## Timing
- Single-cycle ops:
  - START is sampled at edge N.
  - R, RH and flags update at edge N.
  - DONE is high from edge N to edge N+1. Latency is 1.
- Back-to-back single-cycle ops: START may be high on consecutive edges. Each one produces its own DONE pulse, so DONE can stay high over several cycles.
- MUL:
  - START is sampled at edge N, and BUSY is high from edge N.
  - Iterations occur at edges N+1 through N+W.
  - R, RH and flags update at edge N+W, when BUSY falls and DONE rises for one cycle.
  - Latency is W+1 edges.
- A new START is accepted at edge N+W+1 or later.
- Reset asserted during MUL aborts the operation immediately. No DONE is produced, and the outputs go to their reset values.
- DONE never coincides with BUSY=1.

## Test plan
Values are for W=8.
- Reset and ADD:
  - Hold rst_n=0 → all outputs 0.
  - Release, then ADD A=0xFF, B=0x01 → at the next edge R=0x00, CF=1, ZF=1, SF=0, OF=0, DONE for exactly 1 cycle.
- Signed ADD and SUB:
  - ADD 0x7F+0x01 → R=0x80, OF=1, SF=1, CF=0.
  - Then SUB 0x05-0x07 → R=0xFE, CF=1, SF=1, OF=0, ZF=0.
  - This also checks that ZF and SF are cleared from the previous op.
- Shifts:
  - SHR 0x96 by 3 → R=0x12, CF=1.
  - SHL 0x96 by 1 → R=0x2C, CF=1.
  - SHR 0x96 by 9 → R=0x00, ZF=1, CF=0.
  - SHR 0x96 by 0 → R=0x96, CF=0.
- MUL:
  - 0xFF×0xFF → BUSY for 8 cycles, then R=0x01, RH=0xFE, CF=OF=1, DONE 1 cycle.
  - 0x00×0x37 → R=RH=0, ZF=1.
- Ignored START: during a MUL of 0x10×0x10, pulse START with OP=ADD, A=B=0x01 → result is R=0x00, RH=0x01, and no extra DONE appears.
- Reset mid-MUL: drop rst_n 3 cycles into a MUL → outputs go to 0 immediately, with no DONE. After release, an AND of 0xF0 and 0x3C gives R=0x30 normally.
